floo_serial_link_bringup_ctrl: RTL and testbench
================================================

// Module: floo_serial_link_bringup_ctrl
// PURPOSE
//   Sequencer that brings the floo serial link up and down.
//   - Drives the link's clock-gate enable, its synchronous reset and the 2-bit isolate request.
//   - Checks the 2-bit isolated feedback; one software start/stop pulse replaces manual reg pokes.
//   - Sits beside the link wrapper in the clk_i domain; outputs feed the clock gate/reset mux inputs.
// PARAMETERS
//   ClkSettleCycles  default 4     cycles clock runs with reset held before reset-hold count starts
//   ResetHoldCycles  default 16    cycles reset_no stays low after clock settle
//   TimeoutCycles    default 1024  max cycles to wait for isolated_i to reach target
//   CntWidth         derived       $clog2(max of the three above)+1; localparam, not user-set
// PORTS
//   clk_i        in   1  clock
//   rst_ni       in   1  asynchronous active-low reset
//   start_i      in   1  single-cycle pulse: request link up
//   stop_i       in   1  single-cycle pulse: request link down / clear error
//   isolated_i   in   2  isolation status from link, bit0 = in-path, bit1 = out-path, clk_i domain
//   clk_ena_o    out  1  clock-gate enable for link clock
//   reset_no     out  1  link reset, active low
//   isolate_o    out  2  isolation request, same bit mapping as isolated_i
//   link_up_o    out  1  high only in UP
//   busy_o       out  1  high in any transitional state
//   error_o      out  1  high only in ERR
//   state_o      out  3  current state encoding (package enum), for status register
// BEHAVIOUR
//   - All outputs registered. Reset values: clk_ena_o=0, reset_no=0, isolate_o=2'b11, others 0, state OFF.
//   - Async reset mid-operation aborts any state and returns to OFF with the reset values.
//   - One down-counter cnt[CntWidth-1:0]; loaded on each state entry, decrements saturating at 0.
//   States and outputs (clk_ena, reset_no, isolate):
//   - OFF (0,0,11): start_i -> CLK_ON, cnt=ClkSettleCycles-1. Outputs change the cycle after start_i.
//   - CLK_ON (1,0,11): cnt==0 -> RST_HOLD, cnt=ResetHoldCycles-1.
//   - RST_HOLD (1,0,11): cnt==0 -> DEISO, cnt=TimeoutCycles-1; reset_no rises on DEISO entry.
//   - DEISO (1,1,00): isolated_i==00 -> UP; cnt==0 with isolated_i!=00 -> ERR.
//   - UP (1,1,00): stop_i -> ISO, cnt=TimeoutCycles-1. isolated_i change in UP has no effect.
//   - ISO (1,1,11): isolated_i==11 -> OFF; cnt==0 otherwise -> ERR.
//   - ERR (1,0,11): clock kept on for debug, link held in reset. stop_i -> OFF.
//   Boundary conditions:
//   - stop_i in CLK_ON/RST_HOLD/DEISO -> ISO (abort bring-up); stop_i in OFF ignored.
//   - start_i outside OFF ignored; start_i and stop_i in the same cycle: stop wins (OFF: nothing).
//   - Target isolated_i value present on the state-entry cycle: transition next cycle (min 1 cycle/state).
//   - Timeout check and target match in the same cycle: match wins.
//   - Parameters of 1 give a single-cycle state; 0 is illegal (elaboration $error).
//   - busy_o = state in {CLK_ON,RST_HOLD,DEISO,ISO}.
// CONFIGURATION
//   SERIAL_LINK_BRINGUP_TIMEOUT_EN
//   - Defined: DEISO/ISO timeouts active as above; ERR reachable.
//   - Undefined: DEISO/ISO wait indefinitely; ERR unreachable; error_o tied 0; counter used only for settle/hold.
// STRUCTURE
//   - floo_serial_link_bringup_pkg: state_e enum (OFF=0,CLK_ON,RST_HOLD,DEISO,UP,ISO,ERR) and
//     constants IsoAll=2'b11, IsoNone=2'b00.
//   - No sub-module: single FSM plus counter, one always_ff with async reset plus next-state comb.
// TESTING
//   1. Reset, then start_i at t0 with isolated_i following isolate_o after 3 cycles:
//      clk_ena_o=1 at t0+1; reset_no=1 at t0+21; link_up_o=1 at t0+25.
//   2. From UP, stop_i; isolated_i goes 11 after 5 cycles: state ISO, then OFF;
//      clk_ena_o=0, reset_no=0, isolate_o=11.
//   3. TIMEOUT_EN, isolated_i stuck at 01 in DEISO: error_o=1 exactly 1024 cycles after DEISO entry;
//      stop_i -> OFF, error_o=0.
//   4. stop_i during RST_HOLD cycle 5 -> ISO immediately, reset_no stays 0; start_i and stop_i together in UP -> ISO.
//   5. rst_ni pulsed low mid-DEISO: all outputs at reset values asynchronously; state_o=0.
//   6. Macro undefined, isolated_i stuck 01 for 5000 cycles: remains DEISO, error_o=0; release -> UP.

Source files
------------

// File: rtl/floo_serial_link_bringup_pkg.sv
// Shared types and constants for the floo serial link bring-up sequencer.
// Holds the FSM state encoding and the isolate request patterns.
package floo_serial_link_bringup_pkg;

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    CLK_ON   = 3'd1,
    RST_HOLD = 3'd2,
    DEISO    = 3'd3,
    UP       = 3'd4,
    ISO      = 3'd5,
    ERR      = 3'd6
  } state_e;

  localparam logic [1:0] IsoAll  = 2'b11;
  localparam logic [1:0] IsoNone = 2'b00;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/floo_serial_link_bringup_ctrl.sv
// Bring-up/tear-down sequencer for the floo serial link (clock, reset, isolate).
// Optional DEISO/ISO timeouts and ERR state: SERIAL_LINK_BRINGUP_TIMEOUT_EN.
module floo_serial_link_bringup_ctrl
  import floo_serial_link_bringup_pkg::*;
#(
  parameter int ClkSettleCycles = 4,
  parameter int ResetHoldCycles = 16,
  parameter int TimeoutCycles   = 1024
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic [1:0] isolated_i,
  output logic       clk_ena_o,
  output logic       reset_no,
  output logic [1:0] isolate_o,
  output logic       link_up_o,
  output logic       busy_o,
  output logic       error_o,
  output logic [2:0] state_o
);

  localparam int MaxCycles =
    max3(ClkSettleCycles, ResetHoldCycles, TimeoutCycles);
  localparam int CntWidth = $clog2(MaxCycles) + 1;

  localparam logic [CntWidth-1:0] SettleLd =
    CntWidth'(ClkSettleCycles - 1);
  localparam logic [CntWidth-1:0] HoldLd =
    CntWidth'(ResetHoldCycles - 1);
  localparam logic [CntWidth-1:0] ToLd =
    CntWidth'(TimeoutCycles - 1);

`ifdef SERIAL_LINK_BRINGUP_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  if (ClkSettleCycles < 1 || ResetHoldCycles < 1 ||
      TimeoutCycles < 1) begin : g_bad_param
    $error("bringup_ctrl: cycle parameters must be >= 1");
  end

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                clk_ena_q, clk_ena_d;
  logic                rst_n_q, rst_n_d;
  logic [1:0]          iso_q, iso_d;
  logic                up_q, up_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_zero ? cnt_q : cnt_q - 1'b1;
    unique case (state_q)
      OFF: begin
        if (start_i && !stop_i) begin
          state_d = CLK_ON;
          cnt_d   = SettleLd;
        end
      end
      CLK_ON: begin
        if (stop_i) begin
          state_d = ISO;
          cnt_d   = ToLd;
        end else if (cnt_zero) begin
          state_d = RST_HOLD;
          cnt_d   = HoldLd;
        end
      end
      RST_HOLD: begin
        if (stop_i) begin
          state_d = ISO;
          cnt_d   = ToLd;
        end else if (cnt_zero) begin
          state_d = DEISO;
          cnt_d   = ToLd;
        end
      end
      DEISO: begin
        if (stop_i) begin
          state_d = ISO;
          cnt_d   = ToLd;
        end else if (isolated_i == IsoNone) begin
          state_d = UP;
          cnt_d   = '0;
        end else if (TimeoutEn && cnt_zero) begin
          state_d = ERR;
          cnt_d   = '0;
        end
      end
      UP: begin
        if (stop_i) begin
          state_d = ISO;
          cnt_d   = ToLd;
        end
      end
      ISO: begin
        if (isolated_i == IsoAll) begin
          state_d = OFF;
          cnt_d   = '0;
        end else if (TimeoutEn && cnt_zero) begin
          state_d = ERR;
          cnt_d   = '0;
        end
      end
      ERR: begin
        if (stop_i) begin
          state_d = OFF;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = OFF;
        cnt_d   = '0;
      end
    endcase
  end

  // ISO keeps the reset level it was entered with, so an aborted
  // bring-up never releases the link from reset.
  always_comb begin
    clk_ena_d = (state_d != OFF);
    rst_n_d   = 1'b0;
    iso_d     = IsoAll;
    up_d      = (state_d == UP);
    err_d     = TimeoutEn && (state_d == ERR);
    busy_d    = (state_d == CLK_ON) || (state_d == RST_HOLD) ||
                (state_d == DEISO)  || (state_d == ISO);
    unique case (state_d)
      DEISO, UP: begin
        rst_n_d = 1'b1;
        iso_d   = IsoNone;
      end
      ISO:     rst_n_d = rst_n_q;
      default: rst_n_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= OFF;
      cnt_q     <= '0;
      clk_ena_q <= 1'b0;
      rst_n_q   <= 1'b0;
      iso_q     <= IsoAll;
      up_q      <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clk_ena_q <= clk_ena_d;
      rst_n_q   <= rst_n_d;
      iso_q     <= iso_d;
      up_q      <= up_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign clk_ena_o = clk_ena_q;
  assign reset_no  = rst_n_q;
  assign isolate_o = iso_q;
  assign link_up_o = up_q;
  assign busy_o    = busy_q;
  assign error_o   = err_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_floo_serial_link_bringup_ctrl.sv
// Directed bench for floo_serial_link_bringup_ctrl.
// Timeout scenario runs only with SERIAL_LINK_BRINGUP_TIMEOUT_EN.
module tb_floo_serial_link_bringup_ctrl;

  // {clk_ena, reset_n, isolate[1:0], link_up, busy, error, state[2:0]}
  localparam logic [9:0] V_OFF  = {1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 3'd0};
  localparam logic [9:0] V_CLK  = {1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 3'd1};
  localparam logic [9:0] V_HOLD = {1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 3'd2};
  localparam logic [9:0] V_DEI  = {1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 3'd3};
  localparam logic [9:0] V_UP   = {1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 3'd4};
  localparam logic [9:0] V_ISO1 = {1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 3'd5};
  localparam logic [9:0] V_ISO0 = {1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 3'd5};
  localparam logic [9:0] V_ERR  = {1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 3'd6};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       follow = 1'b1;
  logic [1:0] iso_force = 2'b11;
  logic [5:0] pipe = 6'h3f;
  logic [1:0] isolated;
  logic       clk_ena, reset_n, link_up, busy, error;
  logic [1:0] isolate;
  logic [2:0] state;
  logic [9:0] obs;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  // Link model: isolated status tracks the request three cycles late.
  always @(posedge clk) pipe <= {pipe[3:0], isolate};
  assign isolated = follow ? pipe[5:4] : iso_force;
  assign obs = {clk_ena, reset_n, isolate, link_up, busy, error, state};

  floo_serial_link_bringup_ctrl dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .stop_i     (stop),
    .isolated_i (isolated),
    .clk_ena_o  (clk_ena),
    .reset_no   (reset_n),
    .isolate_o  (isolate),
    .link_up_o  (link_up),
    .busy_o     (busy),
    .error_o    (error),
    .state_o    (state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_to_deiso();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++;
    if (obs !== V_OFF) begin
      failures++;
      $display("FAIL reset_vals got=%h exp=%h", obs, V_OFF);
    end
    rst_n = 1'b1;
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (obs !== V_OFF) begin
      failures++;
      $display("FAIL stop_in_off got=%h exp=%h", obs, V_OFF);
    end
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    checks++;
    if (obs !== V_OFF) begin
      failures++;
      $display("FAIL start_stop_off got=%h exp=%h", obs, V_OFF);
    end
  endtask

  task automatic test_bringup();
    follow = 1'b1;
    start  = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (obs !== V_CLK) begin
      failures++;
      $display("FAIL up_t1 got=%h exp=%h", obs, V_CLK);
    end
    repeat (3) tick();
    checks++;
    if (obs !== V_CLK) begin
      failures++;
      $display("FAIL up_t4 got=%h exp=%h", obs, V_CLK);
    end
    tick();
    checks++;
    if (obs !== V_HOLD) begin
      failures++;
      $display("FAIL up_t5 got=%h exp=%h", obs, V_HOLD);
    end
    repeat (15) tick();
    checks++;
    if (obs !== V_HOLD) begin
      failures++;
      $display("FAIL up_t20 got=%h exp=%h", obs, V_HOLD);
    end
    tick();
    checks++;
    if (obs !== V_DEI) begin
      failures++;
      $display("FAIL up_t21 got=%h exp=%h", obs, V_DEI);
    end
    repeat (3) tick();
    checks++;
    if (obs !== V_DEI) begin
      failures++;
      $display("FAIL up_t24 got=%h exp=%h", obs, V_DEI);
    end
    tick();
    checks++;
    if (obs !== V_UP) begin
      failures++;
      $display("FAIL up_t25 got=%h exp=%h", obs, V_UP);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (obs !== V_UP) begin
      failures++;
      $display("FAIL start_in_up got=%h exp=%h", obs, V_UP);
    end
  endtask

  task automatic test_shutdown();
    iso_force = 2'b00;
    follow    = 1'b0;
    stop      = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (obs !== V_ISO1) begin
      failures++;
      $display("FAIL dn_iso got=%h exp=%h", obs, V_ISO1);
    end
    repeat (3) tick();
    checks++;
    if (obs !== V_ISO1) begin
      failures++;
      $display("FAIL dn_wait got=%h exp=%h", obs, V_ISO1);
    end
    iso_force = 2'b11;
    tick();
    checks++;
    if (obs !== V_OFF) begin
      failures++;
      $display("FAIL dn_off got=%h exp=%h", obs, V_OFF);
    end
  endtask

  task automatic test_abort();
    follow    = 1'b0;
    iso_force = 2'b11;
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    checks++;
    if (obs !== V_HOLD) begin
      failures++;
      $display("FAIL ab_hold got=%h exp=%h", obs, V_HOLD);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (obs !== V_ISO0) begin
      failures++;
      $display("FAIL ab_iso got=%h exp=%h", obs, V_ISO0);
    end
    tick();
    checks++;
    if (obs !== V_OFF) begin
      failures++;
      $display("FAIL ab_off got=%h exp=%h", obs, V_OFF);
    end
    follow = 1'b1;
    start  = 1'b1;
    tick();
    start = 1'b0;
    repeat (24) tick();
    checks++;
    if (obs !== V_UP) begin
      failures++;
      $display("FAIL ab_up got=%h exp=%h", obs, V_UP);
    end
    iso_force = 2'b00;
    follow    = 1'b0;
    start     = 1'b1;
    stop      = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    checks++;
    if (obs !== V_ISO1) begin
      failures++;
      $display("FAIL ab_both got=%h exp=%h", obs, V_ISO1);
    end
    iso_force = 2'b11;
    tick();
    checks++;
    if (obs !== V_OFF) begin
      failures++;
      $display("FAIL ab_off2 got=%h exp=%h", obs, V_OFF);
    end
  endtask

`ifdef SERIAL_LINK_BRINGUP_TIMEOUT_EN
  task automatic test_timeout();
    follow    = 1'b0;
    iso_force = 2'b01;
    start_to_deiso();
    checks++;
    if (obs !== V_DEI) begin
      failures++;
      $display("FAIL to_entry got=%h exp=%h", obs, V_DEI);
    end
    repeat (1023) tick();
    checks++;
    if (obs !== V_DEI) begin
      failures++;
      $display("FAIL to_1023 got=%h exp=%h", obs, V_DEI);
    end
    tick();
    checks++;
    if (obs !== V_ERR) begin
      failures++;
      $display("FAIL to_err got=%h exp=%h", obs, V_ERR);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (obs !== V_OFF) begin
      failures++;
      $display("FAIL to_clear got=%h exp=%h", obs, V_OFF);
    end
    iso_force = 2'b11;
  endtask
`else
  task automatic test_no_timeout();
    follow    = 1'b0;
    iso_force = 2'b01;
    start_to_deiso();
    repeat (5000) tick();
    checks++;
    if (obs !== V_DEI) begin
      failures++;
      $display("FAIL nt_stuck got=%h exp=%h", obs, V_DEI);
    end
    iso_force = 2'b00;
    tick();
    checks++;
    if (obs !== V_UP) begin
      failures++;
      $display("FAIL nt_up got=%h exp=%h", obs, V_UP);
    end
    iso_force = 2'b11;
    stop      = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    checks++;
    if (obs !== V_OFF) begin
      failures++;
      $display("FAIL nt_off got=%h exp=%h", obs, V_OFF);
    end
  endtask
`endif

  task automatic test_async_reset();
    follow    = 1'b0;
    iso_force = 2'b01;
    start_to_deiso();
    repeat (3) tick();
    checks++;
    if (obs !== V_DEI) begin
      failures++;
      $display("FAIL ar_deiso got=%h exp=%h", obs, V_DEI);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== V_OFF) begin
      failures++;
      $display("FAIL ar_async got=%h exp=%h", obs, V_OFF);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs !== V_OFF) begin
      failures++;
      $display("FAIL ar_after got=%h exp=%h", obs, V_OFF);
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_shutdown();
    test_abort();
`ifdef SERIAL_LINK_BRINGUP_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
